// File: rtl/prog_mem_loader.sv
// Instruction memory with a host load engine and CPU launch sequencer; fetch is combinational.
// One word per cycle while ld_valid is high; done/start pulse and enable rise one cycle after the last word.
module prog_mem_loader #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 8,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_begin,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [ADDR_W:0]   ld_len,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              ld_abort,
   output logic              ld_busy,
   output logic              ld_done,
   output logic              ld_err,
   output logic [ADDR_W:0]   word_cnt,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [DATA_W-1:0] cpu_instr,
   output logic              cpu_enable,
   output logic              cpu_start
);

   localparam int                DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W+1:0] DEPTH_L = {2'b01, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              wr_en;
   logic              req_ok;
   logic [DATA_W-1:0] mem_q [DEPTH];

   // The window must fit below DEPTH: writes never wrap to address 0.
   assign req_ok = (ld_len != '0) &&
                   (({2'b00, ld_base} + {1'b0, ld_len}) <= DEPTH_L);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE, RUN: begin
            if (ld_begin) begin
               if (req_ok) begin
                  state_d = LOAD;
                  ptr_d   = ld_base;
                  rem_d   = ld_len;
                  cnt_d   = '0;
                  err_d   = 1'b0;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end
         LOAD: begin
            if (ld_abort) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (ld_valid) begin
               wr_en = 1'b1;
               ptr_d = ptr_q + ONE_A;
               cnt_d = cnt_q + ONE_C;
               rem_d = rem_q - ONE_C;
               if (rem_q == ONE_C) state_d = START;
            end
         end
         START:   state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Contents survive reset so a partial image is still inspectable afterwards.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[ptr_q] <= ld_data;
   end

   assign ld_ready   = (state_q == LOAD);
   assign ld_busy    = (state_q == LOAD);
   assign ld_done    = (state_q == START);
   assign cpu_start  = (state_q == START);
   assign cpu_enable = (state_q == START) || (state_q == RUN);
   assign ld_err     = err_q;
   assign word_cnt   = cnt_q;
   assign cpu_instr  = cpu_enable ? mem_q[cpu_addr] : NOP_WORD;

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Parametrised instruction memory with a built-in program-load engine and CPU launch sequencer.
- A host streams instruction words over a valid/ready port into a contiguous address window.
- Once the last word is written, the block releases the pipelined CPU with enable and a one-cycle start pulse.
- Instruction memory has its own private write path, fully decoupled from the data-memory write enable.
- Sits between the testbench/host loader and the CPU fetch port (i_addr/i_datain).

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 8, instruction address width; DEPTH = 2**ADDR_W words
NOP_WORD, 16'h0000, word returned on the fetch port whenever the CPU is not released

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ld_begin  in  1  pulse: start a load session using ld_base/ld_len (sampled same cycle)
ld_base  in  ADDR_W  first address to write
ld_len  in  ADDR_W+1  number of words, 1..DEPTH
ld_valid  in  1  host word valid
ld_data  in  DATA_W  host word
ld_ready  out  1  block accepts word this cycle
ld_abort  in  1  pulse: cancel active load
ld_busy  out  1  load session active
ld_done  out  1  one-cycle pulse when the last word is written
ld_err  out  1  sticky error flag, cleared by the next accepted ld_begin or rst
word_cnt  out  ADDR_W+1  words written in the current/last session
cpu_addr  in  ADDR_W  CPU fetch address
cpu_instr  out  DATA_W  fetched instruction, combinational read
cpu_enable  out  1  CPU enable
cpu_start  out  1  one-cycle CPU start pulse

Behaviour:
- States: IDLE, LOAD, START, RUN.
- Reset:
  - State goes to IDLE.
  - ld_ready, ld_busy, ld_done, ld_err, cpu_enable and cpu_start = 0; word_cnt = 0.
  - Memory contents are NOT cleared.
- IDLE:
  - On ld_begin, check the request.
  - If ld_len==0 or ld_base+ld_len > DEPTH: set ld_err=1 and stay in IDLE. No wrap-around writes, ever.
  - Otherwise: latch the write pointer = ld_base and remaining = ld_len, clear word_cnt and ld_err, go to LOAD.
- LOAD:
  - ld_ready=1 and ld_busy=1.
  - A word transfers when ld_valid&ld_ready: mem[ptr] <= ld_data, ptr++, word_cnt++.
  - A transfer of the final word (word_cnt reaches ld_len): ld_done pulses on the following cycle, ld_ready drops to 0 that same cycle, and the state goes to START.
  - ld_valid low means no transfer; wait indefinitely with no timeout.
  - ld_abort (takes priority over a same-cycle transfer, whose word is discarded): set ld_err=1 and go to IDLE. Words already written remain in memory; word_cnt holds its count.
  - ld_begin while in LOAD is ignored.
- START: one cycle with cpu_enable=1 and cpu_start=1, then go to RUN.
- RUN:
  - cpu_enable=1 and cpu_start=0.
  - ld_begin with a legal request: cpu_enable=0 the next cycle, go to LOAD (hot reload; the CPU is frozen and restarted after reload).
  - ld_begin with an illegal request: set ld_err=1 and stay in RUN.
- Fetch port:
  - cpu_instr = mem[cpu_addr] only in START and RUN; otherwise it is NOP_WORD.
  - No read latency, which matches single-cycle fetch.
- Write/read same address in the same cycle cannot occur, because the fetch port is masked during LOAD.
- rst mid-LOAD or mid-RUN: immediate return to IDLE with all outputs at their reset values; partially loaded words are retained.
- Latency from the last accepted word: ld_done at +1 cycle, cpu_start at +1 cycle, cpu_enable continuously from +1 cycle onward.

Test Plan:
1. Reset, then ld_begin with base=0, len=23. Stream the 23-word sum-loop program (SUB, SUB, NOPs, ADDI gr7=25, ADD/SUBI/BNZ loop, STORE, HALT) with ld_valid held high -> ld_ready high for exactly 23 cycles, word_cnt=23, ld_done and cpu_start each 1 cycle, cpu_enable stays 1. With the CPU and D_MEMORY attached, D_RAM[2]=16'h0145 (sum 1..25=325) after HALT.
2. Load base=8'hF0, len=16 with ld_valid toggling every other cycle -> exactly 16 writes to F0..FF, no wrap to address 0, ld_done after the 16th accepted word.
3. ld_begin with base=8'hF8, len=9, and separately with len=0 -> ld_err=1, state stays IDLE, memory unchanged, ld_ready never asserted.
4. Load base=0, len=10; assert ld_abort together with valid on the 5th word -> 4 words written, word_cnt=4, ld_err=1, no cpu_start, cpu_instr=NOP_WORD.
5. In RUN, issue ld_begin with base=5, len=1, data=16'h1234 -> cpu_enable drops, one write to address 5, a new cpu_start pulse, and cpu_addr=5 returns 16'h1234.
6. Assert rst during LOAD after 3 words -> all outputs 0 the next cycle, words 0..2 retained, and a fresh load succeeds.
